// File: rtl/traffic_pkg.sv
// traffic_pkg: state encodings, lamp constants and lamp decode helpers for the traffic controller
package traffic_pkg;
  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    PED_WALK  = 3'd6,
    EMERG     = 3'd7
  } state_t;
  typedef logic [2:0] lamp_t;
  localparam lamp_t RED    = 3'b100;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b001;
  function automatic lamp_t ns_lamp(state_t s);
    return s == NS_GREEN ? GREEN : s == NS_YELLOW ? YELLOW : RED;
  endfunction
  function automatic lamp_t ew_lamp(state_t s);
    return s == EW_GREEN ? GREEN : s == EW_YELLOW ? YELLOW : RED;
  endfunction
endpackage

// File: rtl/traffic_light_ctrl_timed_dwell_timer.sv
// dwell_timer: loadable down-counter that advances on tick_en and flags expiry on the final tick
module dwell_timer #(
  parameter int CNT_W = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;
  // load on phase entry, otherwise count down once per tick and park at zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (tick_en && cnt != '0) cnt <= cnt - CNT_W'(1);
  end
  assign expired = tick_en && cnt == '0;
endmodule

// File: rtl/traffic_light_ctrl_timed.sv
// traffic_light_ctrl_timed: NS/EW light FSM with dwell timers, all-red clearance, ped walk and emergency
module traffic_light_ctrl_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int GREEN_TICKS  = 20,
  parameter int YELLOW_TICKS = 4,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       ew_car,
  input  logic       emergency,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] state_o
);
  if (GREEN_TICKS < 1 || GREEN_TICKS > 2**CNT_W || YELLOW_TICKS < 1 || YELLOW_TICKS > 2**CNT_W ||
      ALLRED_TICKS < 1 || ALLRED_TICKS > 2**CNT_W || WALK_TICKS < 1 || WALK_TICKS > 2**CNT_W) begin : g_bad_ticks
    $error("traffic_light_ctrl_timed: every *_TICKS must be in [1, 2**CNT_W]");
  end
  localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LD = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LD = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] W_LD = CNT_W'(WALK_TICKS - 1);
  state_t state, nxt;
  logic rest, load, expired;
  logic [CNT_W-1:0] ld_val;
  dwell_timer #(.CNT_W(CNT_W), .RST_VAL(A_LD)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick_en  (tick_en),
    .load     (load),
    .load_val (ld_val),
    .expired  (expired)
  );
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ALLRED_A;
    else state <= nxt;
  end
  // next state: emergency outranks the NS-rest and ped decisions; yellow always runs its full dwell
  always_comb begin
    nxt = state;
    rest = 1'b0;
    case (state)
      ALLRED_A:  nxt = emergency ? EMERG : expired ? NS_GREEN : ALLRED_A;
      NS_GREEN: begin
        nxt = (emergency || (expired && (ew_car || ped_pend))) ? NS_YELLOW : NS_GREEN;
        rest = !emergency && expired && !ew_car && !ped_pend;
      end
      NS_YELLOW: nxt = !expired ? NS_YELLOW : emergency ? EMERG : ALLRED_B;
      ALLRED_B:  nxt = emergency ? EMERG : expired ? EW_GREEN : ALLRED_B;
      EW_GREEN:  nxt = (emergency || expired) ? EW_YELLOW : EW_GREEN;
      EW_YELLOW: nxt = !expired ? EW_YELLOW : emergency ? EMERG : ped_pend ? PED_WALK : ALLRED_A;
      PED_WALK:  nxt = emergency ? EMERG : expired ? ALLRED_A : PED_WALK;
      EMERG:     nxt = emergency ? EMERG : ALLRED_A;
      default:   nxt = ALLRED_A;
    endcase
  end
  // reload the dwell timer on every state entry and on each NS-rest lap
  always_comb begin
    load = (nxt != state) || rest;
    ld_val = (nxt == NS_GREEN || nxt == EW_GREEN) ? G_LD :
             (nxt == NS_YELLOW || nxt == EW_YELLOW) ? Y_LD :
             nxt == PED_WALK ? W_LD : A_LD;
  end
  // pedestrian latch: entering the walk phase clears it, even against a fresh press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ped_pend <= 1'b0;
    else ped_pend <= (nxt == PED_WALK && state != PED_WALK) ? 1'b0 : (ped_pend | ped_req);
  end
  assign light_ns = ns_lamp(state);
  assign light_ew = ew_lamp(state);
  assign walk     = state == PED_WALK;
  assign state_o  = state;
endmodule

// File: tb/tb_traffic_light_ctrl_timed.sv
// tb_traffic_light_ctrl_timed: vector table plus hand sequences, checked through an expectation queue
module tb_traffic_light_ctrl_timed;
  import traffic_pkg::*;
  logic clk, reset_n, tick_en, ped_req, ew_car, emergency;
  logic [2:0] light_ns, light_ew, state_o;
  logic walk, ped_pend;
  typedef struct {
    logic   tick;
    logic   ped;
    logic   car;
    logic   em;
    state_t st;
    logic   pend;
  } vec_t;
  typedef struct {
    state_t st;
    logic   pend;
  } exp_t;
  exp_t sb[$];
  vec_t t1[14];
  state_t t1_st[14];
  int nvec = 0;
  int nbad = 0;
  string tag = "reset";
  traffic_light_ctrl_timed #(
    .CNT_W(8), .GREEN_TICKS(4), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .WALK_TICKS(3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick_en   (tick_en),
    .ped_req   (ped_req),
    .ew_car    (ew_car),
    .emergency (emergency),
    .light_ns  (light_ns),
    .light_ew  (light_ew),
    .walk      (walk),
    .ped_pend  (ped_pend),
    .state_o   (state_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [2:0] exp_ns(state_t s);
    return s == NS_GREEN ? 3'b001 : s == NS_YELLOW ? 3'b010 : 3'b100;
  endfunction
  function automatic logic [2:0] exp_ew(state_t s);
    return s == EW_GREEN ? 3'b001 : s == EW_YELLOW ? 3'b010 : 3'b100;
  endfunction
  task automatic check();
    exp_t x;
    logic bad;
    x = sb.pop_front();
    nvec++;
    bad = state_o !== x.st || light_ns !== exp_ns(x.st) || light_ew !== exp_ew(x.st) ||
          walk !== (x.st == PED_WALK) || ped_pend !== x.pend ||
          (light_ns !== 3'b100 && light_ew !== 3'b100);
    if (bad) begin
      nbad++;
      $display("FAIL %s vec %0d: got state=%0d ns=%b ew=%b walk=%b pend=%b, want state=%0d ns=%b ew=%b walk=%b pend=%b",
               tag, nvec, state_o, light_ns, light_ew, walk, ped_pend,
               x.st, exp_ns(x.st), exp_ew(x.st), x.st == PED_WALK, x.pend);
    end
  endtask
  task automatic step(input logic tk, input logic pd, input logic cr, input logic e,
                      input state_t st, input logic pend);
    tick_en = tk;
    ped_req = pd;
    ew_car = cr;
    emergency = e;
    sb.push_back('{st: st, pend: pend});
    @(posedge clk);
    #1;
    check();
  endtask
  task automatic seq(input int n, input logic tk, input logic cr, input logic e,
                     input state_t st, input logic pend);
    for (int i = 0; i < n; i++) step(tk, 1'b0, cr, e, st, pend);
  endtask
  task automatic check_now(input state_t st, input logic pend);
    sb.push_back('{st: st, pend: pend});
    check();
  endtask
  task automatic run_t1();
    for (int i = 0; i < 14; i++) step(t1[i].tick, t1[i].ped, t1[i].car, t1[i].em, t1[i].st, t1[i].pend);
  endtask
  initial begin
    t1_st = '{NS_GREEN, NS_GREEN, NS_GREEN, NS_GREEN, NS_YELLOW, NS_YELLOW, ALLRED_B,
              EW_GREEN, EW_GREEN, EW_GREEN, EW_GREEN, EW_YELLOW, EW_YELLOW, ALLRED_A};
    for (int i = 0; i < 14; i++)
      t1[i] = '{tick: 1'b1, ped: 1'b0, car: 1'b1, em: 1'b0, st: t1_st[i], pend: 1'b0};
    reset_n = 1'b0;
    tick_en = 1'b1;
    ped_req = 1'b1;
    ew_car = 1'b1;
    emergency = 1'b0;
    #3;
    check_now(ALLRED_A, 1'b0);
    @(posedge clk);
    #1;
    check_now(ALLRED_A, 1'b0);
    ped_req = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_now(ALLRED_A, 1'b0);
    tag = "T1 cycle";
    run_t1();
    tag = "T2 ns rest";
    seq(13, 1'b1, 1'b0, 1'b0, NS_GREEN, 1'b0);
    seq(3, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    seq(2, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_B, 1'b0);
    seq(4, 1'b1, 1'b1, 1'b0, EW_GREEN, 1'b0);
    seq(2, 1'b1, 1'b1, 1'b0, EW_YELLOW, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_A, 1'b0);
    tag = "T3 ped walk";
    seq(1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b1);
    seq(2, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b1);
    seq(2, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b1);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_B, 1'b1);
    seq(4, 1'b1, 1'b1, 1'b0, EW_GREEN, 1'b1);
    seq(2, 1'b1, 1'b1, 1'b0, EW_YELLOW, 1'b1);
    seq(3, 1'b1, 1'b1, 1'b0, PED_WALK, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_A, 1'b0);
    tag = "T4 emergency";
    seq(4, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    seq(2, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_B, 1'b0);
    seq(2, 1'b1, 1'b1, 1'b0, EW_GREEN, 1'b0);
    seq(2, 1'b1, 1'b1, 1'b1, EW_YELLOW, 1'b0);
    seq(10, 1'b1, 1'b1, 1'b1, EMERG, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_A, 1'b0);
    tag = "T5 slow tick";
    seq(1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    for (int k = 0; k < 3; k++) begin
      seq(2, 1'b0, 1'b1, 1'b0, NS_GREEN, 1'b0);
      seq(1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    end
    seq(2, 1'b0, 1'b1, 1'b0, NS_GREEN, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(2, 1'b0, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(2, 1'b0, 1'b1, 1'b0, NS_YELLOW, 1'b0);
    seq(1, 1'b1, 1'b1, 1'b0, ALLRED_B, 1'b0);
    seq(1, 1'b0, 1'b1, 1'b1, EMERG, 1'b0);
    seq(1, 1'b0, 1'b1, 1'b0, ALLRED_A, 1'b0);
    tag = "T6 async reset";
    seq(1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b1);
    seq(2, 1'b1, 1'b1, 1'b0, NS_GREEN, 1'b1);
    seq(1, 1'b1, 1'b1, 1'b0, NS_YELLOW, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_now(ALLRED_A, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_now(ALLRED_A, 1'b0);
    tag = "T6 restart";
    run_t1();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
